// File: rtl/md6_round_engine.sv
// MD6 compression round engine: 89-word feedback shift window, STEPS steps per clock.
// Optional abort input is enabled by defining MD6_ABORT_EN.
module md6_round_engine #(
  parameter int W     = 64,
  parameter int STEPS = 16,
  parameter int B     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [89*W-1:0]   N,
  input  logic [11:0]       r,
  input  logic [16*B-1:0]   R_shift,
  input  logic [16*B-1:0]   L_shift,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [16*W-1:0]   C,
  output logic [11:0]       round_i
`ifdef MD6_ABORT_EN
  ,
  input  logic              abort
`endif
);

  // state | meaning
  // IDLE  | waiting for a block, in_ready high
  // RUN   | STEPS feedback steps per cycle until 16*r steps are done
  // DONE  | C valid, held until out_ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [63:0] S0_FULL    = 64'h0123456789abcdef;
  localparam logic [63:0] SMASK_FULL = 64'h7311c2812425cfa0;
  localparam logic [W-1:0] S0    = S0_FULL[W-1:0];
  localparam logic [W-1:0] SMASK = SMASK_FULL[W-1:0];

  state_t           state;
  logic [89*W-1:0]  win;
  logic [89*W-1:0]  win_next;
  logic [W-1:0]     s_q;
  logic [W-1:0]     s_next;
  logic [15:0]      step_cnt;
  logic [15:0]      step_next;
  logic [15:0]      step_target;
  logic [11:0]      r_q;

`ifdef MD6_ABORT_EN
  logic abort_act;
  assign abort_act = abort;
`endif

  assign C           = win[73*W +: 16*W];
  assign round_i     = step_cnt[15:4];
  assign step_next   = step_cnt + 16'(STEPS);
  assign step_target = {r_q, 4'b0000};
  assign s_next      = {s_q[W-2:0], s_q[W-1]} ^ (s_q & SMASK);

  // ext[0..88] is the current window, ext[89+j] the word produced by step j
  logic [W-1:0] ext [0:88+STEPS];
  logic [W-1:0] x_v;
  logic [3:0]   k_v;

  always_comb begin
    x_v = '0;
    k_v = '0;
    for (int i = 0; i < 89; i++) ext[i] = win[i*W +: W];
    for (int j = 0; j < STEPS; j++) begin
      k_v = step_cnt[3:0] + 4'(j);
      x_v = s_q ^ ext[j] ^ ext[j+72] ^ (ext[j+71] & ext[j+68]) ^ (ext[j+58] & ext[j+22]);
      x_v = x_v ^ (x_v >> R_shift[k_v*B +: B]);
      ext[89+j] = x_v ^ (x_v << L_shift[k_v*B +: B]);
    end
    win_next = '0;
    for (int i = 0; i < 89; i++) win_next[i*W +: W] = ext[i+STEPS];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      step_cnt  <= '0;
      s_q       <= S0;
      win       <= '0;
      r_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            win      <= N;
            r_q      <= r;
            step_cnt <= '0;
            s_q      <= S0;
            in_ready <= 1'b0;
            if (r == 12'd0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
`ifdef MD6_ABORT_EN
          if (abort_act) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end else
`endif
          begin
            win      <= win_next;
            step_cnt <= step_next;
            // S moves on each time a group of 16 steps completes
            if (step_next[3:0] == 4'd0) s_q <= s_next;
            if (step_next == step_target) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
`ifdef MD6_ABORT_EN
          if (abort_act || out_ready) begin
`else
          if (out_ready) begin
`endif
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
